// File: rtl/bin_to_bcd_display_pkg.sv
// Shared types and constants for the binary-to-BCD display converter.
package bin_to_bcd_display_pkg;

    typedef enum logic [1:0] {StIdle, StShift, StSat} state_e;

    localparam int unsigned BcdDigitW = 4;
    localparam logic [3:0]  SatDigit  = 4'h9;

    // Largest value representable in the given number of decimal digits.
    function automatic longint unsigned max_bcd_value(input int unsigned digits);
        longint unsigned v;
        v = 64'd1;
        for (int unsigned i = 0; i < digits; i++) begin
            v = v * 64'd10;
        end
        return v - 64'd1;
    endfunction

    // Decimal digit count of 2^width-1.
    function automatic int unsigned dec_digits_of_max(input int unsigned width);
        longint unsigned v;
        int unsigned     n;
        v = (width >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << width) - 64'd1);
        n = 0;
        while (v != 64'd0) begin
            v = v / 64'd10;
            n++;
        end
        return n;
    endfunction

endpackage

// File: rtl/bin_to_bcd_display_adjust.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
module bcd_digit_adjust (
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    assign o_digit = (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;

endmodule

// File: rtl/bin_to_bcd_display.sv
// Sequential double-dabble converter from unsigned binary to packed BCD, one bit per clock,
// with a registered, held output and saturation to all nines for out-of-range inputs.
module bin_to_bcd_display
    import bin_to_bcd_display_pkg::*;
#(
    parameter int unsigned IN_WIDTH = 27,
    parameter int unsigned DIGITS   = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [IN_WIDTH-1:0]       bin_in,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [BcdDigitW*DIGITS-1:0] bcd_out,
    output logic                      out_valid,
    output logic                      overflow
);

    localparam int unsigned     BcdW   = BcdDigitW * DIGITS;
    localparam int unsigned     CntW   = $clog2(IN_WIDTH) + 1;
    localparam longint unsigned MaxVal = max_bcd_value(DIGITS);
    localparam longint unsigned InMax  = (IN_WIDTH >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF
                                                          : ((64'd1 << IN_WIDTH) - 64'd1);
    // When every input fits in DIGITS digits the limit is the input maximum: never saturate.
    localparam logic [IN_WIDTH:0] SatLimit = (MaxVal >= InMax) ? {1'b0, {IN_WIDTH{1'b1}}}
                                                               : (IN_WIDTH+1)'(MaxVal);

    if (IN_WIDTH < 1) begin : g_bad_width
        $error("bin_to_bcd_display: IN_WIDTH must be at least 1");
    end
    if (dec_digits_of_max(IN_WIDTH) > DIGITS + 1) begin : g_bad_digits
        $error("bin_to_bcd_display: IN_WIDTH too wide for DIGITS");
    end

    state_e              r_state, w_state_nxt;
    logic [IN_WIDTH-1:0] r_shift, w_shift_nxt;
    logic [BcdW-1:0]     r_scratch, w_scratch_nxt;
    logic [CntW-1:0]     r_cnt, w_cnt_nxt;
    logic [BcdW-1:0]     r_bcd, w_bcd_nxt;
    logic                r_out_valid, w_out_valid_nxt;
    logic                r_overflow, w_overflow_nxt;

    logic [BcdW-1:0]     w_adj;
    logic [BcdW-1:0]     w_scratch_shift;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .i_digit (r_scratch[g*BcdDigitW +: BcdDigitW]),
            .o_digit (w_adj[g*BcdDigitW +: BcdDigitW])
        );
    end

    assign w_scratch_shift = {w_adj[BcdW-2:0], r_shift[IN_WIDTH-1]};

    always_comb begin
        w_state_nxt     = r_state;
        w_shift_nxt     = r_shift;
        w_scratch_nxt   = r_scratch;
        w_cnt_nxt       = r_cnt;
        w_bcd_nxt       = r_bcd;
        w_out_valid_nxt = 1'b0;
        w_overflow_nxt  = r_overflow;
        unique case (r_state)
            StIdle: begin
                if (in_valid) begin
                    if ({1'b0, bin_in} > SatLimit) begin
                        w_state_nxt = StSat;
                    end else begin
                        w_shift_nxt   = bin_in;
                        w_scratch_nxt = '0;
                        w_cnt_nxt     = '0;
                        w_state_nxt   = StShift;
                    end
                end
            end
            StShift: begin
                w_shift_nxt   = r_shift << 1;
                w_scratch_nxt = w_scratch_shift;
                w_cnt_nxt     = r_cnt + 1'b1;
                if (r_cnt == CntW'(IN_WIDTH - 1)) begin
                    w_bcd_nxt       = w_scratch_shift;
                    w_out_valid_nxt = 1'b1;
                    w_overflow_nxt  = 1'b0;
                    w_state_nxt     = StIdle;
                end
            end
            StSat: begin
                w_bcd_nxt       = {DIGITS{SatDigit}};
                w_out_valid_nxt = 1'b1;
                w_overflow_nxt  = 1'b1;
                w_state_nxt     = StIdle;
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_shift     <= '0;
            r_scratch   <= '0;
            r_cnt       <= '0;
            r_bcd       <= '0;
            r_out_valid <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_shift     <= w_shift_nxt;
            r_scratch   <= w_scratch_nxt;
            r_cnt       <= w_cnt_nxt;
            r_bcd       <= w_bcd_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_overflow  <= w_overflow_nxt;
        end
    end

    assign in_ready  = (r_state == StIdle);
    assign bcd_out   = r_bcd;
    assign out_valid = r_out_valid;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_bin_to_bcd_display.sv
// Randomised self-checking bench for bin_to_bcd_display against a decimal-arithmetic model.
module tb_bin_to_bcd_display;

    localparam int unsigned MaxIn = 99_999_999;

    logic        clk;
    logic        rst_n;
    logic [26:0] bin_in;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] bcd_out;
    logic        out_valid;
    logic        overflow;

    int n_vec = 0;
    int n_err = 0;

    bin_to_bcd_display dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bin_in    (bin_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bcd_out   (bcd_out),
        .out_valid (out_valid),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Decimal digits of v, most significant digit in the top nibble; all nines when too big.
    function automatic logic [31:0] ref_bcd(input int unsigned v);
        logic [31:0] r;
        int unsigned x;
        if (v > MaxIn) return 32'h9999_9999;
        r = '0;
        x = v;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One conversion: accept v, wait for the result, check latency, value, flags and hold.
    // rst_at > 0 asserts reset after that many edges and returns without waiting for a result.
    task automatic convert(input int unsigned v, input bit busy_poke, input int rst_at);
        logic [31:0] held;
        int          n;
        bit          changed;
        bit          ready_seen;
        int          exp_lat;
        @(negedge clk);
        check("ready_before_accept", in_ready, 1);
        held     = bcd_out;
        bin_in   = v[26:0];
        in_valid = 1'b1;
        @(negedge clk);
        in_valid   = 1'b0;
        bin_in     = 27'($urandom);
        n          = 0;
        changed    = 1'b0;
        ready_seen = 1'b0;
        exp_lat    = (v > MaxIn) ? 1 : 27;
        while (!out_valid && n < 60) begin
            if (busy_poke && n == 5) begin
                in_valid = 1'b1;
                bin_in   = 27'd777;
            end
            if (busy_poke && n == 6) begin
                in_valid = 1'b0;
                bin_in   = 27'd1234;
            end
            if (rst_at > 0 && n == rst_at) begin
                rst_n = 1'b0;
                #1;
                check("midrst_bcd", bcd_out, 0);
                check("midrst_valid", out_valid, 0);
                check("midrst_ovf", overflow, 0);
                check("midrst_ready", in_ready, 1);
                return;
            end
            if (in_ready) ready_seen = 1'b1;
            @(negedge clk);
            n++;
            if (!out_valid && bcd_out !== held) changed = 1'b1;
        end
        check("latency", n, exp_lat);
        check("bcd", bcd_out, ref_bcd(v));
        check("overflow", overflow, (v > MaxIn) ? 1 : 0);
        check("ready_with_valid", in_ready, 1);
        check("hold_during_busy", changed, 0);
        if (exp_lat > 1) check("ready_low_busy", ready_seen, 0);
        held = bcd_out;
        @(negedge clk);
        check("valid_pulse_len", out_valid, 0);
        check("bcd_held", bcd_out, held);
    endtask

    task automatic idle_no_valid(input int cycles, input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check(tag, seen, 0);
    endtask

    initial begin
        int unsigned vals[$];
        int unsigned exp_q[$];
        int          last_t;
        int          t;
        int          done;

        rst_n    = 1'b0;
        in_valid = 1'b1;
        bin_in   = 27'd5;
        repeat (3) @(negedge clk);
        check("rst_bcd", bcd_out, 0);
        check("rst_valid", out_valid, 0);
        check("rst_ovf", overflow, 0);
        check("rst_ready", in_ready, 1);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        idle_no_valid(30, "no_accept_in_reset");

        // Directed values, including digit boundaries and the saturation edge.
        vals = '{0, 12_345_678, 99_999_999, 9, 10, 100_000_000, 42};
        foreach (vals[i]) convert(vals[i], 1'b0, 0);

        // Busy request must be ignored; no stray conversion afterwards.
        convert(555, 1'b1, 0);
        idle_no_valid(35, "busy_req_ignored");

        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 3) == 0) convert($urandom_range(MaxIn + 1, 27'h7FF_FFFF), 1'b0, 0);
            else convert($urandom_range(0, MaxIn), 1'b0, 0);
        end

        // Back-to-back with in_valid held high.
        @(negedge clk);
        exp_q.push_back($urandom_range(0, MaxIn));
        bin_in   = exp_q[0][26:0];
        in_valid = 1'b1;
        last_t   = 0;
        done     = 0;
        t        = 0;
        while (done < 4 && t < 400) begin
            @(negedge clk);
            t++;
            if (out_valid) begin
                check("b2b_bcd", bcd_out, ref_bcd(exp_q.pop_front()));
                if (done > 0) check("b2b_period", t - last_t, 28);
                last_t = t;
                done++;
                if (done < 4) begin
                    exp_q.push_back($urandom_range(0, MaxIn));
                    bin_in = exp_q[exp_q.size()-1][26:0];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        check("b2b_count", done, 4);
        in_valid = 1'b0;
        idle_no_valid(30, "b2b_drained");

        // Reset in the middle of a conversion, then a clean retry.
        convert(31_415_926, 1'b0, 10);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle_no_valid(30, "no_valid_after_midrst");
        convert(31_415_926, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_display.md
Name: bin_to_bcd_display

Overview:
- Sequential double-dabble converter that turns an unsigned binary count into packed BCD for the 8-digit seven-segment driver.
- Sits directly upstream of the seven-segment driver. Its 32-bit output drives that driver's `val` input, so each hex digit displays as a decimal digit.
- Output is held stable between conversions, so the display never shows partial results.

Parameters:
- IN_WIDTH, 27, width of binary input; 27 covers 99_999_999.
- DIGITS, 8, number of BCD digits; output width is 4*DIGITS.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- bin_in  input  IN_WIDTH  unsigned value to convert.
- in_valid  input  1  request; accepted when in_valid && in_ready at a rising edge.
- in_ready  output  1  high only in IDLE.
- bcd_out  output  4*DIGITS  packed BCD, digit 0 in [3:0]; registered and held.
- out_valid  output  1  one-cycle pulse in the cycle bcd_out first shows a new result.
- overflow  output  1  registered; high while the held bcd_out is a saturated result.

Behaviour:
- Reset:
  - Asynchronous on rst_n low, released synchronously to clk.
  - State returns to IDLE. bcd_out=0, out_valid=0, overflow=0, in_ready=1, shift counter=0, scratch registers=0.
  - Reset mid-conversion abandons the conversion; no out_valid is produced.
- States: IDLE, SHIFT, SAT.
- IDLE:
  - in_ready=1; out_valid is cleared after its single-cycle pulse.
  - On accept with bin_in <= 10^DIGITS-1: latch bin_in into the shift register, clear the BCD scratch, set counter=0, go to SHIFT.
  - On accept with bin_in > 10^DIGITS-1: go to SAT.
- SHIFT (one iteration per clock):
  - For every scratch digit >= 5, add 3 (4-bit, no carry between digits).
  - Shift {scratch, shift_reg} left by 1; scratch LSB takes the shift_reg MSB.
  - counter increments.
  - On the iteration where counter==IN_WIDTH-1: write the shifted scratch to bcd_out, set out_valid=1, set overflow=0, return to IDLE.
- SAT:
  - Write all-9s (0x99999999 at the defaults) to bcd_out, set out_valid=1, set overflow=1, return to IDLE.
  - This takes one cycle.
- Latency, counting from the accept edge:
  - Normal path: result and out_valid appear after exactly IN_WIDTH further rising edges.
  - Saturation path: after 1 further edge.
  - in_ready is high again in the same cycle that out_valid is high.
- Back-to-back requests:
  - A request held high is accepted in the out_valid cycle.
  - Throughput is one conversion per IN_WIDTH+1 cycles.
- in_valid while busy: ignored; bin_in is sampled only at accept, so later changes have no effect.
- bcd_out changes only in the out_valid cycle or on reset.
- Width rules:
  - Internal scratch is 4*DIGITS bits; counter width is clog2(IN_WIDTH)+1.
  - The saturation compare is done at IN_WIDTH+1 bits against the constant.
- Elaboration check: IN_WIDTH must be >= 1 and 2^IN_WIDTH-1 must need at most DIGITS+1 decimal digits; violations raise a $error.

Decomposition:
- Shared package holds:
  - the state enum typedef (IDLE, SHIFT, SAT);
  - the BCD digit width constant (4);
  - a function returning 10^DIGITS-1;
  - the saturation digit constant (4'h9).
- One sub-module: bcd_digit_adjust. It is purely combinational, 4-bit in and 4-bit out, computing the add-3-if->=5 step.
  - The converter instantiates DIGITS copies in a generate loop.

Test Plan:
- Reset check: hold rst_n=0 with in_valid=1, then release. Required: bcd_out=0, out_valid=0, overflow=0, in_ready=1; no accept occurs while in reset.
- Zero input: bin_in=0 accepted. Required: after exactly 27 edges, bcd_out=0x00000000, out_valid high for 1 cycle, overflow=0.
- Nominal and boundary values:
  - 12_345_678 → bcd_out=0x12345678.
  - 99_999_999 → 0x99999999 with overflow=0.
  - 9 → 0x00000009; 10 → 0x00000010.
- Saturation: bin_in=100_000_000 → 1 edge later bcd_out=0x99999999, overflow=1. A following input of 42 → bcd_out=0x00000042 with overflow cleared.
- Busy and back-to-back behaviour:
  - Accept 555. While in SHIFT, pulse in_valid with bin_in=777 and also change bin_in. Required: result is 0x00000555 and the 777 request is not accepted.
  - Hold in_valid high continuously. Required: conversions complete every 28 cycles.
- Reset mid-conversion: assert rst_n=0 at iteration 10 of converting 31_415_926. Required: bcd_out immediately 0 and no out_valid. After release, a fresh conversion of 31_415_926 yields 0x31415926.
